// File: rtl/pad_pkg.sv
// Shared types and helpers for the IFM zero-padding writer.
// Holds the writer state encoding, the padding default and the pad-position test.
package pad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } pad_state_e;

    localparam int PAD_MAX_DEF = 3;
    localparam int POS_W       = 16;

    // A padded position lies in the top/bottom border rows or left/right border columns.
    function automatic logic pad_pos(input logic [POS_W-1:0] r,
                                     input logic [POS_W-1:0] x,
                                     input logic [POS_W-1:0] p,
                                     input logic [POS_W-1:0] w,
                                     input logic [POS_W-1:0] h);
        return (r < p) || (r >= h + p) || (x < p) || (x >= w + p);
    endfunction

endpackage

// File: rtl/pad_scan_counter.sv
// Nested word/column/row scan counters for the padded tensor walk.
// Exposes the post-advance position so the caller can classify the next word.
module pad_scan_counter #(
    parameter int DIM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIM_W-1:0] wpp_i,
    input  logic [DIM_W:0]   pw_i,
    input  logic [DIM_W:0]   ph_i,
    output logic [DIM_W:0]   x_nxt_o,
    output logic [DIM_W:0]   r_nxt_o,
    output logic             row_last_o,
    output logic             last_o
);

    logic [DIM_W-1:0] k_q, k_d;
    logic [DIM_W:0]   x_q, x_d;
    logic [DIM_W:0]   r_q, r_d;
    logic             k_last, x_last, r_last;

    assign k_last     = (k_q == wpp_i - DIM_W'(1));
    assign x_last     = (x_q == pw_i - (DIM_W+1)'(1));
    assign r_last     = (r_q == ph_i - (DIM_W+1)'(1));
    assign row_last_o = k_last && x_last;
    assign last_o     = k_last && x_last && r_last;

    always_comb begin
        k_d = k_q;
        x_d = x_q;
        r_d = r_q;
        if (en_i) begin
            if (k_last) begin
                k_d = '0;
                if (x_last) begin
                    x_d = '0;
                    r_d = r_q + (DIM_W+1)'(1);
                end else begin
                    x_d = x_q + (DIM_W+1)'(1);
                end
            end else begin
                k_d = k_q + DIM_W'(1);
            end
        end
    end

    assign x_nxt_o = x_d;
    assign r_nxt_o = r_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0;
            x_q <= '0;
            r_q <= '0;
        end else if (clr_i) begin
            k_q <= '0;
            x_q <= '0;
            r_q <= '0;
        end else begin
            k_q <= k_d;
            x_q <= x_d;
            r_q <= r_d;
        end
    end

endmodule

// File: rtl/ifm_pad_writer.sv
// Streams un-padded OFM words into memory as a zero-bordered IFM tensor.
// Handshake: a word is consumed when in_valid && in_ready; in_ready depends only on state.
module ifm_pad_writer
    import pad_pkg::*;
#(
    parameter int PE      = 16,
    parameter int ADDR_W  = 32,
    parameter int DIM_W   = 8,
    parameter int PAD_MAX = PAD_MAX_DEF,
    localparam int PADW   = $clog2(PAD_MAX+1),
    localparam int DW     = PE*8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_c,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [PADW-1:0]   cfg_pad,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DW-1:0]     wr_data,
    output logic              row_done,
    output logic [DIM_W+1:0]  rows_written,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam logic [31:0] PAD_MAX_U = PAD_MAX;

    pad_state_e        state_q, state_d;
    logic [DIM_W-1:0]  wpp_q, w_q, h_q;
    logic [DIM_W:0]    pw_q, ph_q;
    logic [PADW-1:0]   pad_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DIM_W+1:0]  rows_q;
    logic              row_done_q, cfg_err_q;

    logic              cfg_ok, start_ok, start_bad;
    logic [DIM_W:0]    x_nxt, r_nxt;
    logic              row_last, last;

    assign cfg_ok = (cfg_c >= DIM_W'(PE)) && ((cfg_c % DIM_W'(PE)) == '0) &&
                    (cfg_w != '0) && (cfg_h != '0) && (32'(cfg_pad) <= PAD_MAX_U);
    assign start_ok  = (state_q == IDLE) && start && cfg_ok;
    assign start_bad = (state_q == IDLE) && start && !cfg_ok;

    pad_scan_counter #(.DIM_W(DIM_W)) u_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (start_ok),
        .en_i       (wr_en),
        .wpp_i      (wpp_q),
        .pw_i       (pw_q),
        .ph_i       (ph_q),
        .x_nxt_o    (x_nxt),
        .r_nxt_o    (r_nxt),
        .row_last_o (row_last),
        .last_o     (last)
    );

    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        wr_data  = '0;
        unique case (state_q)
            IDLE: if (start_ok) state_d = (cfg_pad != '0) ? PAD : DATA;
            PAD: begin
                wr_en = 1'b1;
                busy  = 1'b1;
            end
            DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                wr_en    = in_valid;
                wr_data  = in_data;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // The position after this write decides whether the next word is border or data.
        if (wr_en) begin
            if (last) state_d = DONE;
            else if (pad_pos(POS_W'(r_nxt), POS_W'(x_nxt), POS_W'(pad_q),
                             POS_W'(w_q), POS_W'(h_q))) state_d = PAD;
            else state_d = DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wpp_q      <= '0;
            w_q        <= '0;
            h_q        <= '0;
            pw_q       <= '0;
            ph_q       <= '0;
            pad_q      <= '0;
            addr_q     <= '0;
            rows_q     <= '0;
            row_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_err_q  <= start_bad;
            row_done_q <= wr_en && row_last;
            if (start_ok) begin
                wpp_q  <= DIM_W'(cfg_c / DIM_W'(PE));
                w_q    <= cfg_w;
                h_q    <= cfg_h;
                pad_q  <= cfg_pad;
                pw_q   <= (DIM_W+1)'(cfg_w) + ((DIM_W+1)'(cfg_pad) << 1);
                ph_q   <= (DIM_W+1)'(cfg_h) + ((DIM_W+1)'(cfg_pad) << 1);
                addr_q <= cfg_base;
                rows_q <= '0;
            end else begin
                if (wr_en) addr_q <= addr_q + ADDR_W'(1);
                if (wr_en && row_last) rows_q <= rows_q + (DIM_W+2)'(1);
            end
        end
    end

    assign wr_addr      = addr_q;
    assign row_done     = row_done_q;
    assign rows_written = rows_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_ifm_pad_writer.sv
// Directed-plus-random bench for ifm_pad_writer against a loop-nest model of the padded tensor.
module tb_ifm_pad_writer;

    localparam int PE = 16;
    localparam int AW = 32;
    localparam int DIM_W = 8;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    cfg_c = '0, cfg_w = '0, cfg_h = '0;
    logic [1:0]    cfg_pad = '0;
    logic [AW-1:0] cfg_base = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, wr_en, row_done, busy, done, cfg_err;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DIM_W+1:0] rows_written;

    ifm_pad_writer #(.PE(PE), .ADDR_W(AW), .DIM_W(DIM_W), .PAD_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_c(cfg_c), .cfg_w(cfg_w),
        .cfg_h(cfg_h), .cfg_pad(cfg_pad), .cfg_base(cfg_base), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .row_done(row_done), .rows_written(rows_written),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] in_q[$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_row_done"}, row_done, 0);
        chk({tag, "_rows_written"}, rows_written, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    // Builds the expected write stream from the padded-tensor loop nest, then drives and checks one tensor.
    task automatic run_tensor(input int c, input int w, input int h, input int p,
                              input logic [AW-1:0] base, input int stall_pct, input int poke_at);
        int wpp, pw, ph, n_wr, j, idx, stalls, rd, err, data_cyc;
        bit fin, is_pad;
        wpp = c / PE; pw = w + 2*p; ph = h + 2*p; n_wr = ph*pw*wpp;
        j = 0; idx = 0; stalls = 0; rd = 0; err = 0; data_cyc = 0; fin = 0;
        exp_q.delete(); exp_addr_q.delete(); in_q.delete();
        for (int i = 0; i < h*w*wpp; i++)
            in_q.push_back({$urandom, $urandom, $urandom, $urandom} | 128'h1);
        for (int r = 0; r < ph; r++)
            for (int x = 0; x < pw; x++)
                for (int k = 0; k < wpp; k++) begin
                    is_pad = (r < p) || (r >= h + p) || (x < p) || (x >= w + p);
                    exp_q.push_back(is_pad ? '0 : in_q[j]);
                    if (!is_pad) j++;
                    exp_addr_q.push_back(base + AW'(idx));
                    idx++;
                end
        start = 1'b1; cfg_c = 8'(c); cfg_w = 8'(w); cfg_h = 8'(h); cfg_pad = 2'(p); cfg_base = base;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 4000 && !fin; cyc++) begin
            in_valid = (in_q.size() != 0) && ($urandom_range(99) >= stall_pct);
            in_data = in_valid ? in_q[0] : {$urandom, $urandom, $urandom, $urandom};
            if (cyc == poke_at) begin start = 1'b1; cfg_c = 8'd24; end
            else start = 1'b0;
            #1;
            if (cfg_err) err++;
            if (row_done) rd++;
            if (done) begin
                fin = 1;
                chk("done_cycle", cyc, n_wr + stalls + 1);
                chk("busy_at_done", busy, 0);
                chk("wr_en_at_done", wr_en, 0);
                chk("rows_written_final", rows_written, ph);
                chk("row_done_count", rd, ph);
                chk("writes_missing", exp_q.size(), 0);
                chk("inputs_left", in_q.size(), 0);
                chk("data_accept_cycles", data_cyc, h*w*wpp);
            end else begin
                chk("busy_in_run", busy, 1);
                if (in_ready && !in_valid) stalls++;
                if (in_ready && in_valid) begin data_cyc++; void'(in_q.pop_front()); end
                if (wr_en) begin
                    if (exp_q.size() == 0) chk("extra_write", 1, 0);
                    else begin
                        chk("wr_addr", wr_addr, exp_addr_q.pop_front());
                        chk("wr_data", wr_data, exp_q.pop_front());
                    end
                end else begin
                    chk("idle_write_only_on_stall", in_ready && !in_valid, 1);
                end
            end
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0;
        if (!fin) chk("timeout_waiting_done", 0, 1);
        chk("cfg_err_during_run", err, 0);
        #1;
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic check_reject(input int c, input int w, input int h, input int p, input string tag);
        start = 1'b1; cfg_c = 8'(c); cfg_w = 8'(w); cfg_h = 8'(h); cfg_pad = 2'(p);
        cfg_base = 32'h500;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({tag, "_cfg_err"}, cfg_err, 1);
        chk({tag, "_no_write"}, wr_en, 0);
        chk({tag, "_not_busy"}, busy, 0);
        @(negedge clk);
        #1;
        chk({tag, "_cfg_err_pulse"}, cfg_err, 0);
        chk({tag, "_still_idle"}, wr_en || busy, 0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_tensor(16, 2, 2, 1, 32'h100, 0, 0);
        run_tensor(32, 3, 1, 0, $urandom, 0, 0);
        run_tensor(16, 2, 2, 1, 32'h100, 30, 0);
        run_tensor(16, 1, 1, 3, 32'h40, 0, 0);

        check_reject(24, 2, 2, 1, "c24");
        check_reject(0, 2, 2, 1, "c0");
        check_reject(16, 0, 2, 1, "w0");
        check_reject(16, 2, 0, 0, "h0");

        run_tensor(16, 3, 3, 2, 32'h300, 20, 4);
        run_tensor(48, 2, 3, 1, 32'hFFFF_FFF8, 15, 0);

        for (int t = 0; t < 4; t++)
            run_tensor(16 * $urandom_range(1, 3), $urandom_range(1, 4), $urandom_range(1, 4),
                       $urandom_range(0, 3), $urandom, $urandom_range(0, 40), 0);

        start = 1'b1; cfg_c = 8'd16; cfg_w = 8'd2; cfg_h = 8'd2; cfg_pad = 2'd1; cfg_base = 32'h200;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1;
        repeat (7) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        #1;
        chk("midreset_no_write", wr_en, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        run_tensor(16, 2, 2, 1, 32'h200, 10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ifm_pad_writer.md
# ifm_pad_writer

Parametrised zero-padding writer placed between a conv/pointwise output stage and the next layer's IFM buffer. It takes a stream of un-padded OFM words (PE channels × 8 bit per word) and writes the padded tensor into on-chip memory. The output has (H+2P) rows × (W+2P) columns × C channels, channel-fastest, at consecutive word addresses from a base. Unlike the previous padding controller, it supports:
- independent W and H;
- runtime padding 0..PAD_MAX;
- input back-pressure;
- a per-row progress count for the downstream line-window consumer.

## Interface
Parameters:
- PE, 16: channels per data word; word width PE*8.
- ADDR_W, 32: write-address width.
- DIM_W, 8: width of C/W/H configuration fields.
- PAD_MAX, 3: largest legal padding; cfg_pad width is $clog2(PAD_MAX+1).

Ports:
- Reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  begin one tensor; sampled only in IDLE
- cfg_c  in  DIM_W  channels; must be a nonzero multiple of PE
- cfg_w  in  DIM_W  un-padded width, ≥1
- cfg_h  in  DIM_W  un-padded height, ≥1
- cfg_pad  in  $clog2(PAD_MAX+1)  padding P, ≤PAD_MAX
- cfg_base  in  ADDR_W  first write address (word units)
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  PE*8  un-padded OFM word
- wr_en  out  1  memory write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  PE*8  write data
- row_done  out  1  one-cycle pulse after the last word of each padded row
- rows_written  out  DIM_W+2  padded rows completed in this tensor
- busy  out  1  tensor in progress
- done  out  1  one-cycle pulse after the last write
- cfg_err  out  1  one-cycle pulse when start is rejected

## Operation
- **Configuration latch:** on start in IDLE, cfg_* is latched. From the latched values:
  - WPP = cfg_c/PE
  - PW = cfg_w+2P
  - PH = cfg_h+2P
- **Rejected start:** if cfg_c<PE, cfg_c%PE≠0, cfg_w=0, cfg_h=0 or cfg_pad>PAD_MAX, start is dropped and cfg_err pulses the next cycle; the block stays in IDLE.
- **Scan order:** row r in 0..PH-1, column x in 0..PW-1, word k in 0..WPP-1.
- **Pad position:** r<P, r≥cfg_h+P, x<P or x≥cfg_w+P.
- **States:**
  - IDLE: all strobes low.
  - PAD: writes a zero word every cycle with no input consumed; in_ready=0.
  - DATA: in_ready=1; writes in_data only when in_valid=1. With in_valid=0 nothing is written and the counters and address hold.
  - DONE: 1 cycle; pulses done, then goes to IDLE.
- **Transitions:** after each written word, advance k→x→r and select PAD or DATA from the new position. After the final word (r=PH-1, x=PW-1, k=WPP-1) go to DONE. With P=0 the PAD state is never entered.
- **Addressing:** wr_addr = cfg_base + linear index, incremented by 1 per written word, wrapping modulo 2^ADDR_W.
- **Datapath:** wr_data = 0 in PAD, in_data in DATA.
- **Combinational outputs:** wr_en = PAD | (DATA & in_valid); in_ready = DATA.
- **Row progress:** rows_written increments with each row_done and clears on start. It lets a K×K consumer begin once rows_written ≥ K.
- **Ignored start:** start while busy is ignored and does not raise cfg_err.
- **Accepted words:** exactly cfg_h*cfg_w*WPP input words are accepted per tensor.

## Timing
- Reset values: every output 0; state IDLE; all counters 0.
- The first write happens the cycle after start is accepted, at address cfg_base. busy rises in that same cycle.
- Throughput: 1 word/cycle when in_valid is held high.
- Total writes = PH*PW*WPP. Cycle count = PH*PW*WPP + input stall cycles.
- row_done is registered: it is high the cycle after the write of (x=PW-1, k=WPP-1).
- done is high one cycle after the final write. busy falls in the same cycle.
- Reset mid-tensor: immediately back to IDLE; no further writes; rows_written=0.
- in_data is consumed when in_valid & in_ready are both high. There is no internal buffering and no combinational path from in_valid to in_ready.

## Structure
- Package pad_pkg holds:
  - the state enum (IDLE, PAD, DATA, DONE);
  - the PAD_MAX default;
  - a function computing the pad_pos predicate.
- One sub-module, pad_scan_counter: nested k/x/r counters with enable, wrap limits (WPP, PW, PH), and last-word/last-row flags.
- The top level holds the FSM, the address register, the data mux and the row/done pulse logic.

## Test plan
- C=16, W=2, H=2, P=1, base=0x100, in_valid held high: 16 writes to 0x100..0x10F. Nonzero data only at offsets 5, 6, 9 and 10; row_done ×4; done at cycle 17.
- C=32, W=3, H=1, P=0: 6 writes, all input data, in_ready high for all 6 cycles, done one cycle after the 6th write, rows_written=1.
- Back-pressure, same configuration as the first case: in_valid low for 3 cycles in DATA → wr_en=0, and wr_addr/counters hold. Completion takes 19 cycles; data order is preserved.
- P=3, C=16, W=1, H=1: 49 writes; the only data word is at offset 24; in_ready is high for exactly 1 cycle.
- Invalid configurations:
  - cfg_c=24 → cfg_err pulse, no writes.
  - start pulsed while busy → ignored, no cfg_err, output unchanged.
- Reset asserted mid-row → all outputs 0 next edge. A subsequent start re-runs from cfg_base.
